// File: rtl/ir_emitter_pkg.sv
// Shared IR project constants: system clock, carrier frequency, emitter states.
// Also provides the carrier half-period helper used by emitter and receiver.
package ir_emitter_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned CARRIER_HZ = 38_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int unsigned half_clks(
        input int unsigned clk_hz,
        input int unsigned car_hz
    );
        return clk_hz / (2 * car_hz);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: HALF high / HALF low, CYCLES periods while i_en is high.
// Ports: clk, rst, i_en (BURST state), o_level (carrier), o_last (final clock).
module ir_carrier_gen #(
    parameter int unsigned HALF   = 657,
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_level,
    output logic o_last
);

    localparam int unsigned HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned PW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [HW-1:0] HALF_TOP = HW'(HALF - 1);
    localparam logic [PW-1:0] PER_TOP  = PW'(CYCLES - 1);

    logic [HW-1:0] r_half_cnt;
    logic [PW-1:0] r_period;
    logic          r_low;
    logic          w_half_end;

    assign w_half_end = (r_half_cnt == HALF_TOP);
    assign o_level    = i_en & ~r_low;
    assign o_last     = i_en & r_low & w_half_end & (r_period == PER_TOP);

    // Counters rest at zero outside the burst so each burst starts high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half_cnt <= '0;
            r_period   <= '0;
            r_low      <= 1'b0;
        end else if (!i_en || o_last) begin
            r_half_cnt <= '0;
            r_period   <= '0;
            r_low      <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_low      <= ~r_low;
            if (r_low) begin
                r_period <= r_period + 1'b1;
            end
        end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ir_emitter.sv
// IR proximity emitter: sends carrier bursts and flags echoes seen on ir_rx.
// Ports: clk, rst, test_enable, start, ir_rx in; ir_led, busy, done, echo out.
module ir_emitter #(
    parameter int unsigned CLK_HZ       = ir_emitter_pkg::CLK_HZ,
    parameter int unsigned CARRIER_HZ   = ir_emitter_pkg::CARRIER_HZ,
    parameter int unsigned BURST_CYCLES = 16,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned ECHO_MIN     = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic test_enable,
    input  logic start,
    input  logic ir_rx,
    output logic ir_led,
    output logic busy,
    output logic done,
    output logic echo
);

    import ir_emitter_pkg::*;

    localparam int unsigned HALF    = half_clks(CLK_HZ, CARRIER_HZ);
    localparam int unsigned GAP_LEN = 2 * HALF * GAP_CYCLES;
    localparam int unsigned GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int unsigned RW = $clog2(ECHO_MIN + 1);
    localparam logic [GW-1:0] GAP_TOP  = GW'(GAP_LEN - 1);
    localparam logic [RW-1:0] ECHO_TOP = RW'(ECHO_MIN);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [GW-1:0] r_gap_cnt;
    logic [RW-1:0] r_run;
    logic [RW-1:0] w_run_nxt;
    logic          r_hit;
    logic          r_done;
    logic          r_echo;
    logic          w_in_burst;
    logic          w_in_gap;
    logic          w_burst_last;
    logic          w_gap_last;
    logic          w_carrier;
    logic          w_rx_low;
    logic          w_enter_burst;
    logic          w_seq_end;

    ir_carrier_gen #(
        .HALF   (HALF),
        .CYCLES (BURST_CYCLES)
    ) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_in_burst),
        .o_level (w_carrier),
        .o_last  (w_burst_last)
    );

    assign w_in_burst    = (r_state == ST_BURST);
    assign w_in_gap      = (r_state == ST_GAP);
    assign w_gap_last    = w_in_gap & (r_gap_cnt == GAP_TOP);
    assign w_rx_low      = ~r_rx_sync;
    assign w_enter_burst = (r_state == ST_IDLE) & start & ~test_enable;
    // A test-mode abort on the last gap clock suppresses done.
    assign w_seq_end     = w_gap_last & ~test_enable;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !test_enable) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (test_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_burst_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (test_enable || w_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: all derived from registered state
    always_comb begin
        ir_led = w_carrier;
        busy   = (r_state != ST_IDLE);
        done   = r_done;
        echo   = r_echo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
        end else begin
            r_rx_meta <= ir_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (w_in_gap && !w_gap_last) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Saturating run length of synchronized low samples, burst only.
    always_comb begin
        w_run_nxt = '0;
        if (w_in_burst && w_rx_low) begin
            w_run_nxt = (r_run == ECHO_TOP) ? r_run : r_run + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= '0;
            r_hit <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
            if (w_enter_burst) begin
                r_hit <= 1'b0;
            end else if (w_in_burst && (w_run_nxt == ECHO_TOP)) begin
                r_hit <= 1'b1;
            end
        end
    end

    // echo updates on the same edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_echo <= 1'b0;
        end else begin
            r_done <= w_seq_end;
            if (w_seq_end) begin
                r_echo <= r_hit;
            end
        end
    end

endmodule

// File: tb/tb_ir_emitter.sv
// Directed bench for ir_emitter with an echo scoreboard.
// Small parameters: HALF=5, 4 burst periods, 4 gap periods, ECHO_MIN=3.
module tb_ir_emitter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic test_enable = 1'b0;
    logic start = 1'b0;
    logic ir_rx = 1'b1;
    logic ir_led;
    logic busy;
    logic done;
    logic echo;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_q[$];

    ir_emitter #(
        .CLK_HZ       (1000),
        .CARRIER_HZ   (100),
        .BURST_CYCLES (4),
        .GAP_CYCLES   (4),
        .ECHO_MIN     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .test_enable (test_enable),
        .start       (start),
        .ir_rx       (ir_rx),
        .ir_led      (ir_led),
        .busy        (busy),
        .done        (done),
        .echo        (echo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_led(input int k);
        return (k <= 40) && (((k - 1) % 10) < 5);
    endfunction

    function automatic logic [79:0] lo(
        input logic [79:0] p,
        input int a,
        input int b
    );
        for (int i = a; i <= b; i++) begin
            p[i-1] = 1'b0;
        end
        return p;
    endfunction

    // Runs one full burst+gap; pat[k-1] is ir_rx during sequence clock k.
    task automatic do_seq(
        input logic [79:0] pat,
        input bit started,
        input bit chain,
        input string name
    );
        bit e;
        if (!started) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 1; k <= 80; k++) begin
            ir_rx = pat[k-1];
            chk($sformatf("%s led@%0d", name, k), ir_led, exp_led(k));
            chk($sformatf("%s busy@%0d", name, k), busy, 1'b1);
            chk($sformatf("%s done@%0d", name, k), done, 1'b0);
            step();
        end
        ir_rx = 1'b1;
        chk({name, " done_pulse"}, done, 1'b1);
        chk({name, " busy_end"}, busy, 1'b0);
        chk({name, " led_end"}, ir_led, 1'b0);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s scoreboard: observed done expected none", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, " echo"}, echo, e);
        end
        if (chain) start = 1'b1;
        step();
        start = 1'b0;
        if (!chain) chk({name, " done_once"}, done, 1'b0);
    endtask

    initial begin
        logic [79:0] ones;
        logic [79:0] p;
        int rc_list[2];
        ones = '1;
        rc_list = '{7, 3};

        #1 rst = 1'b1;
        #1;
        chk("rst_async led", ir_led, 1'b0);
        chk("rst_async busy", busy, 1'b0);
        chk("rst_async done", done, 1'b0);
        chk("rst_async echo", echo, 1'b0);
        step();
        chk("rst busy", busy, 1'b0);
        chk("rst echo", echo, 1'b0);
        rst = 1'b0;
        step();

        exp_q.push_back(1'b0);
        do_seq(ones, 1'b0, 1'b0, "basic");
        exp_q.push_back(1'b1);
        do_seq(lo(ones, 10, 20), 1'b0, 1'b0, "hit1");
        exp_q.push_back(1'b0);
        do_seq(ones, 1'b0, 1'b0, "clear");
        exp_q.push_back(1'b1);
        do_seq(lo(ones, 10, 20), 1'b0, 1'b0, "hit2");
        p = lo(lo(lo(ones, 5, 6), 15, 16), 25, 26);
        exp_q.push_back(1'b0);
        do_seq(p, 1'b0, 1'b0, "short_runs");
        exp_q.push_back(1'b1);
        do_seq(lo(ones, 10, 20), 1'b0, 1'b0, "hit3");
        exp_q.push_back(1'b0);
        do_seq(lo(ones, 43, 78), 1'b0, 1'b0, "gap_low");
        exp_q.push_back(1'b1);
        do_seq(lo(ones, 10, 20), 1'b0, 1'b0, "hit4");

        // test mode abort during burst
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("abort led@%0d", k), ir_led, exp_led(k));
            chk($sformatf("abort busy@%0d", k), busy, 1'b1);
            if (k == 12) test_enable = 1'b1;
            step();
        end
        chk("abort led_off", ir_led, 1'b0);
        chk("abort busy_off", busy, 1'b0);
        for (int k = 0; k < 60; k++) begin
            chk($sformatf("abort no_done@%0d", k), done, 1'b0);
            chk($sformatf("abort idle@%0d", k), busy, 1'b0);
            step();
        end
        chk("abort echo_kept", echo, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("tm_start busy@%0d", k), busy, 1'b0);
            chk($sformatf("tm_start led@%0d", k), ir_led, 1'b0);
            step();
        end
        test_enable = 1'b0;
        step();

        // reset mid-burst, then start on the first edge after release
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (rc_list[j]) begin
            for (int k = 1; k <= rc_list[j]; k++) begin
                chk($sformatf("rst%0d led@%0d", j, k), ir_led, exp_led(k));
                chk($sformatf("rst%0d busy@%0d", j, k), busy, 1'b1);
                if (k < rc_list[j]) step();
            end
            rst = 1'b1;
            #1;
            chk($sformatf("rst%0d led0", j), ir_led, 1'b0);
            chk($sformatf("rst%0d busy0", j), busy, 1'b0);
            chk($sformatf("rst%0d echo0", j), echo, 1'b0);
            chk($sformatf("rst%0d done0", j), done, 1'b0);
            #2;
            rst = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
            chk($sformatf("rst%0d restart led", j), ir_led, 1'b1);
            chk($sformatf("rst%0d restart busy", j), busy, 1'b1);
        end

        exp_q.push_back(1'b0);
        do_seq(ones, 1'b1, 1'b1, "chain_a");
        exp_q.push_back(1'b1);
        do_seq(lo(ones, 10, 20), 1'b1, 1'b0, "chain_b");

        chk("scoreboard empty", exp_q.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
